// File: rtl/seq_div.sv
// Restoring unsigned divider: DW-bit dividend by VW-bit divisor, one quotient bit per clock.
// Latency: done is high DW cycles after the accepted start; two cycles for a zero divisor.
// Backpressure: start is taken only in IDLE or DONE; later starts and operand changes are ignored.
module seq_div #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = $clog2(DW + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_ZERO = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dvd_q;
    logic [VW-1:0] div_q;
    logic [VW-1:0] rem_q;

    logic [VW:0]   r_shift;
    logic [VW:0]   r_sub;
    logic          ge;
    logic [VW-1:0] rem_nxt;
    logic          accept;

    // The partial remainder is always below the divisor, so r_shift < 2*divisor and
    // the borrow bit of the VW+1-bit subtraction alone decides the compare.
    always_comb begin
        r_shift = {rem_q, dvd_q[DW-1]};
        r_sub   = r_shift - {1'b0, div_q};
        ge      = ~r_sub[VW];
        rem_nxt = ge ? r_sub[VW-1:0] : r_shift[VW-1:0];
    end

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);

    // dvd_q doubles as the quotient shift register: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            dvd_q       <= '0;
            div_q       <= '0;
            rem_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        dvd_q <= dividend;
                        div_q <= divisor;
                        rem_q <= '0;
                        cnt   <= '0;
                        state <= (divisor == '0) ? S_ZERO : S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    rem_q <= rem_nxt;
                    dvd_q <= {dvd_q[DW-2:0], ge};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(DW - 1)) begin
                        quotient    <= {dvd_q[DW-2:0], ge};
                        remainder   <= rem_nxt;
                        div_by_zero <= 1'b0;
                        state       <= S_DONE;
                    end
                end
                S_ZERO: begin
                    // Dwell two cycles so a zero divisor completes two edges after start.
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(1)) begin
                        quotient    <= '1;
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                        state       <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: expected results are queued at issue and compared on done.
module tb_seq_div;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } res_t;

    res_t sb[$];
    res_t mon_e;
    int   checks = 0;
    int   failures = 0;

    seq_div #(.DW(8), .VW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [7:0] d, input logic [3:0] v);
        res_t e;
        if (v == 4'd0) begin
            e.q = 8'hFF; e.r = 4'd0; e.dz = 1'b1;
        end else begin
            e.q = d / {4'd0, v};
            e.r = 4'(d % {4'd0, v});
            e.dz = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check_val("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_val("quotient", 32'(quotient), 32'(mon_e.q));
                check_val("remainder", 32'(remainder), 32'(mon_e.r));
                check_val("div_by_zero", 32'(div_by_zero), 32'(mon_e.dz));
                check_val("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    // Drive one start pulse; returns 2 time units after the accepting edge.
    task automatic issue(input logic [7:0] d, input logic [3:0] v, input bit push);
        @(negedge clk);
        dividend = d;
        divisor  = v;
        start    = 1'b1;
        if (push) sb.push_back(model(d, v));
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_lat, input string tag, input int lat0);
        int lat;
        lat = lat0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #2;
            lat++;
        end
        check_val(tag, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_q"}, 32'(quotient), 32'd0);
        check_val({tag, "_r"}, 32'(remainder), 32'd0);
        check_val({tag, "_dz"}, 32'(div_by_zero), 32'd0);
    endtask

    initial begin
        #3 rst_n = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        issue(8'd200, 4'd7, 1'b1);
        check_val("busy_run", 32'(busy), 32'd1);
        wait_done(8, "lat_200_7", 0);

        issue(8'd64, 4'd8, 1'b1);   wait_done(8, "lat_64_8", 0);
        issue(8'd255, 4'd15, 1'b1); wait_done(8, "lat_255_15", 0);
        issue(8'd3, 4'd5, 1'b1);    wait_done(8, "lat_3_5", 0);
        issue(8'd15, 4'd1, 1'b1);   wait_done(8, "lat_15_1", 0);

        repeat (4) @(posedge clk);
        #2;
        check_val("hold_idle_q", 32'(quotient), 32'd15);
        check_val("hold_idle_done", 32'(done), 32'd0);

        issue(8'd100, 4'd9, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        check_val("hold_mid_q", 32'(quotient), 32'd15);
        check_val("hold_mid_r", 32'(remainder), 32'd0);
        wait_done(8, "lat_100_9", 3);

        issue(8'd8, 4'd0, 1'b1);
        check_val("busy_zero", 32'(busy), 32'd0);
        wait_done(2, "lat_div0", 0);

        // start held across a whole run with operands changed mid-flight
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd7;
        start    = 1'b1;
        sb.push_back(model(8'd200, 4'd7));
        sb.push_back(model(8'd9, 4'd3));
        @(posedge clk);
        #2;
        repeat (3) @(posedge clk);
        #2;
        dividend = 8'd9;
        divisor  = 4'd3;
        wait_done(8, "lat_held_first", 3);
        @(posedge clk);
        #2;
        start = 1'b0;
        check_val("busy_b2b", 32'(busy), 32'd1);
        wait_done(8, "lat_b2b", 0);

        // reset in the middle of a run
        issue(8'd200, 4'd7, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1 check_idle_outputs("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        check_val("midrst_no_done", 32'(done), 32'd0);
        issue(8'd50, 4'd6, 1'b1);
        wait_done(8, "lat_50_6", 0);

        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            logic [3:0] v;
            d = 8'($urandom_range(0, 255));
            v = 4'($urandom_range(0, 15));
            issue(d, v, 1'b1);
            wait_done((v == 4'd0) ? 2 : 8, "lat_rand", 0);
        end

        repeat (3) @(posedge clk);
        #2;
        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
